// File: rtl/rect_plotter.sv
// Rectangle / outline / clear drawing engine that streams one pixel write per clock
// into the VGA adapter, with one command accepted per start/done handshake.
module rect_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      w,
  input  logic [Y_W-1:0]      h,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FIN} state_t;

  localparam logic [1:0] M_OUTLINE = 2'b01;
  localparam logic [1:0] M_CLEAR   = 2'b10;
  localparam logic [1:0] M_NOP     = 2'b11;

  state_t r_state, w_stateNext;

  logic [1:0]          r_mode;
  logic [X_W-1:0]      r_x0, r_w, r_col;
  logic [Y_W-1:0]      r_y0, r_h, r_row;
  logic [COLOUR_W-1:0] r_colourLatch;
  logic                r_busy, r_done, r_plot;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [COLOUR_W-1:0] r_colour;

  logic [1:0]          w_effMode;
  logic [X_W-1:0]      w_effX0, w_effW, w_posCol;
  logic [Y_W-1:0]      w_effY0, w_effH, w_posRow;
  logic [COLOUR_W-1:0] w_effColour;
  logic                w_lastCol, w_lastRow, w_lastPos, w_empty;
  logic [X_W:0]        w_sumX;
  logic [Y_W:0]        w_sumY;
  logic                w_onScreen, w_edge, w_selected, w_plotNext;

  // In IDLE the box comes straight from the inputs (first position 0,0); in DRAW it
  // comes from the latched command and the position is the one after the current.
  always_comb begin
    w_effMode   = r_mode;
    w_effX0     = r_x0;
    w_effY0     = r_y0;
    w_effW      = r_w;
    w_effH      = r_h;
    w_effColour = r_colourLatch;
    w_lastCol   = (r_col == r_w - X_W'(1));
    w_lastRow   = (r_row == r_h - Y_W'(1));
    w_lastPos   = w_lastCol && w_lastRow;
    w_posCol    = w_lastCol ? '0 : r_col + 1'b1;
    w_posRow    = w_lastCol ? r_row + 1'b1 : r_row;
    if (r_state == S_IDLE) begin
      w_effMode   = mode;
      w_effColour = colour_in;
      w_posCol    = '0;
      w_posRow    = '0;
      if (mode == M_CLEAR) begin
        w_effX0 = '0;
        w_effY0 = '0;
        w_effW  = X_W'(SCREEN_W);
        w_effH  = Y_W'(SCREEN_H);
      end else begin
        w_effX0 = x0;
        w_effY0 = y0;
        w_effW  = w;
        w_effH  = h;
      end
    end
    w_empty    = (w_effMode == M_NOP) || (w_effW == '0) || (w_effH == '0);
    w_sumX     = {1'b0, w_effX0} + {1'b0, w_posCol};
    w_sumY     = {1'b0, w_effY0} + {1'b0, w_posRow};
    w_onScreen = (w_sumX < (X_W+1)'(SCREEN_W)) && (w_sumY < (Y_W+1)'(SCREEN_H));
    w_edge     = (w_posRow == '0) || (w_posRow == w_effH - Y_W'(1)) ||
                 (w_posCol == '0) || (w_posCol == w_effW - X_W'(1));
    w_selected = (w_effMode == M_OUTLINE) ? w_edge : 1'b1;
    w_plotNext = w_onScreen && w_selected;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (start) w_stateNext = w_empty ? S_FIN : S_DRAW;
      S_DRAW:  if (w_lastPos) w_stateNext = S_FIN;
      S_FIN:   w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Every cycle spent in DRAW presents one box position; clipped or unselected
  // positions still take their cycle but leave x/y/colour untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode        <= '0;
      r_x0          <= '0;
      r_y0          <= '0;
      r_w           <= '0;
      r_h           <= '0;
      r_colourLatch <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_plot        <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_colour      <= '0;
    end else begin
      r_busy <= (w_stateNext == S_DRAW);
      r_done <= (w_stateNext == S_FIN);
      r_plot <= 1'b0;
      if (r_state == S_IDLE && start) begin
        r_mode        <= w_effMode;
        r_x0          <= w_effX0;
        r_y0          <= w_effY0;
        r_w           <= w_effW;
        r_h           <= w_effH;
        r_colourLatch <= w_effColour;
      end
      if (w_stateNext == S_DRAW) begin
        r_col  <= w_posCol;
        r_row  <= w_posRow;
        r_plot <= w_plotNext;
        if (w_plotNext) begin
          r_x      <= w_sumX[X_W-1:0];
          r_y      <= w_sumY[Y_W-1:0];
          r_colour <= w_effColour;
        end
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign plot   = r_plot;
  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;

endmodule
